// File: rtl/sram_tile_mover.sv
// sram_tile_mover
//   Moves one TILE_H x TILE_W tile between SRAM and the IDCT dual-port
//   buffers.
//   Read mode (Mode=0): fetches 16-bit coefficients from SRAM and writes
//   them, sign-extended, into the coefficient buffer.
//   Write mode (Mode=1): reads result samples in pairs, clips them to
//   8 bits and writes one packed pixel pair per SRAM word.
//   Base address and row stride are free, so one engine serves the Y, U
//   and V planes at any block size.
//
// Build option:
//   SRAM_TILE_MOVER_CLIP_EN  defined   : samples saturate to 0..255
//                            undefined : samples are truncated to [7:0]
//
// Ports:
//   Clock, Resetn            system clock, asynchronous active-low reset
//   Start, Mode              start pulse (sampled in IDLE only), direction
//   Base_address, Row_stride SRAM position of element (0,0), words per row
//   Buf_base                 buffer address of element (0,0)
//   Busy, Done               operation in progress, completion pulse
//   SRAM_*                   SRAM address/data/write-enable (active low)
//   Buf_wr_*, Buf_we         coefficient buffer write port
//   Buf_rd_address_a/b       result buffer read addresses (even/odd sample)
//   Buf_read_data_a/b        result buffer read data, one cycle after address
//
// State      | meaning
// -----------+-------------------------------------------------------
// S_IDLE     | waiting for Start
// S_RD_ISSUE | one SRAM read address per cycle
// S_RD_DRAIN | waiting for the last read word to reach the buffer
// S_WR_ISSUE | one buffer read address pair per cycle
// S_WR_DRAIN | waiting for the last packed word to reach SRAM
// S_FINISH   | Done pulse
module sram_tile_mover #(
  parameter int ADDR_W      = 18,
  parameter int TILE_W      = 8,
  parameter int TILE_H      = 8,
  parameter int BUF_AW      = 7,
  parameter int SRAM_RD_LAT = 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Mode,
  input  logic [ADDR_W-1:0] Base_address,
  input  logic [ADDR_W-1:0] Row_stride,
  input  logic [BUF_AW-1:0] Buf_base,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] SRAM_address,
  input  logic [15:0]       SRAM_read_data,
  output logic [15:0]       SRAM_write_data,
  output logic              SRAM_we_n,
  output logic [BUF_AW-1:0] Buf_wr_address,
  output logic [31:0]       Buf_write_data,
  output logic              Buf_we,
  output logic [BUF_AW-1:0] Buf_rd_address_a,
  output logic [BUF_AW-1:0] Buf_rd_address_b,
  input  logic [31:0]       Buf_read_data_a,
  input  logic [31:0]       Buf_read_data_b
);

  localparam int N_ELEM = TILE_W * TILE_H;
  localparam int N_WORD = N_ELEM / 2;
  localparam int CW     = BUF_AW + 1;

  localparam logic [CW-1:0] RD_LAST  = CW'(N_ELEM - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(N_WORD - 1);
  localparam logic [CW-1:0] RD_COLS  = CW'(TILE_W - 1);
  localparam logic [CW-1:0] WR_COLS  = CW'(TILE_W / 2 - 1);
  localparam logic [CW-1:0] RD_XFERS = CW'(N_ELEM);
  localparam logic [CW-1:0] WR_XFERS = CW'(N_WORD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_DRAIN,
    S_WR_ISSUE,
    S_WR_DRAIN,
    S_FINISH
  } state_t;

  state_t state;

  logic [ADDR_W-1:0]      stride_q;
  logic [ADDR_W-1:0]      row_addr;
  logic [ADDR_W-1:0]      elem_addr;
  logic [ADDR_W-1:0]      word_addr_d;
  logic [CW-1:0]          col;
  logic [CW-1:0]          issue_left;
  logic [CW-1:0]          xfer_left;
  logic [BUF_AW-1:0]      wr_ptr;
  logic [SRAM_RD_LAT-1:0] rd_vld;
  logic                   wr_vld;

  logic              issue_rd;
  logic              issue_wr;
  logic              row_end;
  logic [CW-1:0]     col_last;
  logic [ADDR_W-1:0] next_row;
  logic [ADDR_W-1:0] next_elem;
  logic [7:0]        pix_a;
  logic [7:0]        pix_b;

  // In write mode the generator walks SRAM words (half a row of samples
  // per row), in read mode it walks samples.
  always_comb begin
    issue_rd  = (state == S_RD_ISSUE);
    issue_wr  = (state == S_WR_ISSUE);
    col_last  = issue_wr ? WR_COLS : RD_COLS;
    row_end   = (col == col_last);
    next_row  = row_end ? row_addr + stride_q : row_addr;
    next_elem = row_end ? row_addr + stride_q : elem_addr + ADDR_W'(1);
  end

`ifdef SRAM_TILE_MOVER_CLIP_EN
  function automatic logic [7:0] clip8(input logic [31:0] v);
    if (v[31])
      return 8'h00;
    else if (|v[30:8])
      return 8'hFF;
    else
      return v[7:0];
  endfunction

  assign pix_a = clip8(Buf_read_data_a);
  assign pix_b = clip8(Buf_read_data_b);
`else
  logic unused_hi;

  assign pix_a     = Buf_read_data_a[7:0];
  assign pix_b     = Buf_read_data_b[7:0];
  assign unused_hi = ^{Buf_read_data_a[31:8], Buf_read_data_b[31:8]};
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state            <= S_IDLE;
      Busy             <= 1'b0;
      Done             <= 1'b0;
      SRAM_address     <= '0;
      SRAM_write_data  <= '0;
      SRAM_we_n        <= 1'b1;
      Buf_wr_address   <= '0;
      Buf_write_data   <= '0;
      Buf_we           <= 1'b0;
      Buf_rd_address_a <= '0;
      Buf_rd_address_b <= '0;
      stride_q         <= '0;
      row_addr         <= '0;
      elem_addr        <= '0;
      word_addr_d      <= '0;
      col              <= '0;
      issue_left       <= '0;
      xfer_left        <= '0;
      wr_ptr           <= '0;
      rd_vld           <= '0;
      wr_vld           <= 1'b0;
    end else begin
      Done      <= 1'b0;
      Buf_we    <= 1'b0;
      SRAM_we_n <= 1'b1;

      // rd_vld tracks each issued read through the SRAM latency; the top
      // bit marks the cycle in which that word is on SRAM_read_data.
      rd_vld      <= (rd_vld << 1) | SRAM_RD_LAT'(issue_rd);
      // Buffer read data lags the address by one cycle, so the SRAM word
      // address rides one register behind the generator.
      wr_vld      <= issue_wr;
      word_addr_d <= elem_addr;

      if (rd_vld[SRAM_RD_LAT-1]) begin
        Buf_we         <= 1'b1;
        Buf_wr_address <= wr_ptr;
        Buf_write_data <= {{16{SRAM_read_data[15]}}, SRAM_read_data};
        wr_ptr         <= wr_ptr + BUF_AW'(1);
        xfer_left      <= xfer_left - CW'(1);
      end

      if (wr_vld) begin
        SRAM_we_n       <= 1'b0;
        SRAM_address    <= word_addr_d;
        SRAM_write_data <= {pix_a, pix_b};
        xfer_left       <= xfer_left - CW'(1);
      end

      case (state)
        S_IDLE: begin
          if (Start) begin
            Busy             <= 1'b1;
            stride_q         <= Row_stride;
            row_addr         <= Base_address;
            elem_addr        <= Base_address;
            col              <= '0;
            wr_ptr           <= Buf_base;
            Buf_rd_address_a <= Buf_base;
            Buf_rd_address_b <= Buf_base + BUF_AW'(1);
            if (Mode) begin
              issue_left <= WR_LAST;
              xfer_left  <= WR_XFERS;
              state      <= S_WR_ISSUE;
            end else begin
              issue_left   <= RD_LAST;
              xfer_left    <= RD_XFERS;
              SRAM_address <= Base_address;
              state        <= S_RD_ISSUE;
            end
          end
        end

        S_RD_ISSUE: begin
          if (issue_left == '0) begin
            state <= S_RD_DRAIN;
          end else begin
            issue_left   <= issue_left - CW'(1);
            elem_addr    <= next_elem;
            row_addr     <= next_row;
            col          <= row_end ? '0 : col + CW'(1);
            SRAM_address <= next_elem;
          end
        end

        S_WR_ISSUE: begin
          if (issue_left == '0) begin
            state <= S_WR_DRAIN;
          end else begin
            issue_left       <= issue_left - CW'(1);
            elem_addr        <= next_elem;
            row_addr         <= next_row;
            col              <= row_end ? '0 : col + CW'(1);
            Buf_rd_address_a <= Buf_rd_address_a + BUF_AW'(2);
            Buf_rd_address_b <= Buf_rd_address_b + BUF_AW'(2);
          end
        end

        // The transfer counter reaches zero on the last transfer, so the
        // cycle showing that transfer is the one before Done.
        S_RD_DRAIN: begin
          if (Buf_we && (xfer_left == '0)) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_FINISH;
          end
        end

        S_WR_DRAIN: begin
          if (!SRAM_we_n && (xfer_left == '0)) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_FINISH;
          end
        end

        S_FINISH: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
